// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Stall/flush sequencer for a 5-stage pipeline: load-use bubbles,
//             taken-branch flushes, dmem wait/timeout handling, stall counter.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_ex_rt,
  input  logic             ctrl_memRead_id_ex,
  input  logic             ctrl_branch_ex_mem,
  input  logic             zero_ex_mem,
  input  logic             ctrl_memRead_ex_mem,
  input  logic             ctrl_memWrite_ex_mem,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_wait_nxt;
  logic             r_mem_err;
  logic             w_err_set;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             w_freeze;
  logic             w_hazard_eval;
  logic             w_mem_op;
  logic             w_taken;
  logic             w_load_use;

  assign w_mem_op   = ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem;
  assign w_taken    = ctrl_branch_ex_mem & zero_ex_mem;
  assign w_load_use = ctrl_memRead_id_ex && (id_ex_rt != 5'd0) &&
                      ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));

  always_comb begin
    pc_write      = 1'b1;
    pc_src        = 1'b0;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b1;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;
    dmem_req      = 1'b0;
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_err_set     = 1'b0;
    w_freeze      = 1'b0;
    w_hazard_eval = 1'b0;

    case (r_state)
      RUN: begin
        if (w_mem_op) begin
          dmem_req = 1'b1;
          if (!dmem_ready) begin
            w_freeze    = 1'b1;
            w_state_nxt = MEM_WAIT;
            w_wait_nxt  = 8'd1;
          end else begin
            w_hazard_eval = 1'b1;
          end
        end else begin
          w_hazard_eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          // Access completes: a pending load-use bubble is taken this same cycle
          w_state_nxt   = RUN;
          w_wait_nxt    = 8'd0;
          w_hazard_eval = 1'b1;
        end else begin
          w_freeze = 1'b1;
          if (r_wait_cnt == c_MAX_WAIT) begin
            w_state_nxt = ERR;
            w_err_set   = 1'b1;
          end else begin
            w_wait_nxt = r_wait_cnt + 8'd1;
          end
        end
      end
      ERR: begin
        w_freeze = 1'b1;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase

    if (w_freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
    end

    if (w_hazard_eval) begin
      if (w_taken) begin
        pc_src       = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (w_load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    if (!reset) begin
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_write = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
      dmem_req     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= RUN;
      r_wait_cnt     <= 8'd0;
      r_mem_err      <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_err_set) begin
        r_mem_err <= 1'b1;
      end
      if (!pc_write && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
    end
  end

  assign mem_err      = r_mem_err;
  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Directed self-checking bench for pipeline_hazard_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, id_ex_rt;
  logic        id_uses_rt, ctrl_memRead_id_ex, ctrl_branch_ex_mem, zero_ex_mem;
  logic        ctrl_memRead_ex_mem, ctrl_memWrite_ex_mem, dmem_ready;
  logic        pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic        ex_mem_write, ex_mem_flush, mem_wb_flush, dmem_req, mem_err;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  // {pc_write,pc_src,if_id_write,if_id_flush,id_ex_write,id_ex_flush,ex_mem_write,ex_mem_flush,mem_wb_flush,dmem_req}
  localparam logic [9:0] ZERO   = 10'b0000000000;
  localparam logic [9:0] DEF    = 10'b1010101000;
  localparam logic [9:0] MEMOK  = 10'b1010101001;
  localparam logic [9:0] FRZ    = 10'b0000000011;
  localparam logic [9:0] LU     = 10'b0000111000;
  localparam logic [9:0] LUREQ  = 10'b0000111001;
  localparam logic [9:0] BR     = 10'b1111111100;
  localparam logic [9:0] ERROUT = 10'b0000000010;

  logic [9:0] w_outs;
  assign w_outs = {pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                   ex_mem_write, ex_mem_flush, mem_wb_flush, dmem_req};

  pipeline_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_ex_rt(id_ex_rt),
    .ctrl_memRead_id_ex(ctrl_memRead_id_ex), .ctrl_branch_ex_mem(ctrl_branch_ex_mem),
    .zero_ex_mem(zero_ex_mem), .ctrl_memRead_ex_mem(ctrl_memRead_ex_mem),
    .ctrl_memWrite_ex_mem(ctrl_memWrite_ex_mem), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .dmem_req(dmem_req), .mem_err(mem_err),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs = 5'd0; id_rt = 5'd0; id_ex_rt = 5'd0; id_uses_rt = 1'b0;
    ctrl_memRead_id_ex = 1'b0; ctrl_branch_ex_mem = 1'b0; zero_ex_mem = 1'b0;
    ctrl_memRead_ex_mem = 1'b0; ctrl_memWrite_ex_mem = 1'b0; dmem_ready = 1'b0;
  endtask

  initial begin
    clr();
    reset = 1'b0;
    step();
    #2 chk("reset_outs", 32'(w_outs), 32'(ZERO));
    step();
    chk("reset_cnt", stall_cycles, 32'd0);
    chk("reset_err", 32'(mem_err), 32'd0);
    reset = 1'b1;
    #2 chk("idle_def", 32'(w_outs), 32'(DEF));

    // T1: load-use on rs, then on rt
    step();
    ctrl_memRead_id_ex = 1'b1; id_ex_rt = 5'd2; id_rs = 5'd2; id_rt = 5'd7; id_uses_rt = 1'b1;
    #2 chk("lu_rs", 32'(w_outs), 32'(LU));
    step();
    chk("lu_cnt1", stall_cycles, 32'd1);
    id_rs = 5'd9; id_rt = 5'd2;
    #2 chk("lu_rt", 32'(w_outs), 32'(LU));
    step();
    chk("lu_cnt2", stall_cycles, 32'd2);

    // T2: no-stall corner cases
    id_ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #2 chk("lu_r0", 32'(w_outs), 32'(DEF));
    step();
    id_ex_rt = 5'd3; id_rt = 5'd3; id_rs = 5'd5; id_uses_rt = 1'b0;
    #2 chk("lu_no_rt", 32'(w_outs), 32'(DEF));
    step();
    chk("nostall_cnt", stall_cycles, 32'd2);

    // T3: taken branch beats a concurrent load-use; not-taken gives defaults
    ctrl_branch_ex_mem = 1'b1; zero_ex_mem = 1'b1; id_uses_rt = 1'b1;
    #2 chk("br_taken", 32'(w_outs), 32'(BR));
    step();
    clr();
    ctrl_branch_ex_mem = 1'b1; zero_ex_mem = 1'b0;
    #2 chk("br_not", 32'(w_outs), 32'(DEF));
    step();
    chk("br_cnt", stall_cycles, 32'd2);

    // T4: store with three wait states
    clr();
    ctrl_memWrite_ex_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2 chk($sformatf("sw_wait%0d", i), 32'(w_outs), 32'(FRZ));
      step();
    end
    dmem_ready = 1'b1;
    #2 chk("sw_done", 32'(w_outs), 32'(MEMOK));
    step();
    clr();
    #2 chk("sw_after", 32'(w_outs), 32'(DEF));
    chk("sw_cnt", stall_cycles, 32'd5);

    // Load in ex_mem with a dependent ID instruction: freeze, then bubble on completion
    step();
    ctrl_memRead_ex_mem = 1'b1; ctrl_memRead_id_ex = 1'b1; id_ex_rt = 5'd4; id_rs = 5'd4;
    #2 chk("ld_dep_wait", 32'(w_outs), 32'(FRZ));
    step();
    dmem_ready = 1'b1;
    #2 chk("ld_dep_done", 32'(w_outs), 32'(LUREQ));
    step();
    clr();
    chk("ld_dep_cnt", stall_cycles, 32'd7);

    // T5: timeout with MAX_WAIT=4
    ctrl_memRead_ex_mem = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2 chk($sformatf("to_wait%0d", i), 32'(w_outs), 32'(FRZ));
      step();
    end
    #2 chk("err_outs", 32'(w_outs), 32'(ERROUT));
    chk("err_flag", 32'(mem_err), 32'd1);
    step();
    dmem_ready = 1'b1;
    #2 chk("err_sticky_outs", 32'(w_outs), 32'(ERROUT));
    step();
    chk("err_sticky", 32'(mem_err), 32'd1);
    chk("err_cnt", stall_cycles, 32'd14);

    // T6: reset clears ERR; reset mid MEM_WAIT drops outputs immediately
    reset = 1'b0;
    #2 chk("err_rst_outs", 32'(w_outs), 32'(ZERO));
    step();
    reset = 1'b1;
    clr();
    chk("rst_err_clr", 32'(mem_err), 32'd0);
    chk("rst_cnt_clr", stall_cycles, 32'd0);
    ctrl_memWrite_ex_mem = 1'b1;
    step();
    #2 chk("mw_frz", 32'(w_outs), 32'(FRZ));
    reset = 1'b0;
    #1 chk("mw_rst_outs", 32'(w_outs), 32'(ZERO));
    step();
    reset = 1'b1;
    clr();
    #2 chk("mw_rst_run", 32'(w_outs), 32'(DEF));
    chk("mw_rst_cnt", stall_cycles, 32'd0);
    chk("mw_rst_err", 32'(mem_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
